// File: rtl/booth_multiplier_if.sv
// Operand/result bundle for booth_multiplier.
//   a, b     : 8-bit two's-complement multiplicand / multiplier (driven by master)
//   product  : 16-bit signed product, registered (driven by slave)
//   block    : current Booth recoding triplet, 000 outside the step phase (driven by slave)
interface booth_multiplier_if;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] product;
    logic [2:0]  block;

    modport master (
        output a,
        output b,
        input  product,
        input  block
    );

    modport slave (
        input  a,
        input  b,
        output product,
        output block
    );
endinterface

// File: rtl/booth_multiplier.sv
// Sequential 8x8 signed multiplier using radix-4 (modified Booth) recoding of b.
// A multiplication is armed by reset; after release the FSM walks IDLE -> LOAD ->
// four STEP edges -> DONE, so product is valid 6 rising edges after reset release.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset; clears all state and arms a new multiply
//   bus  : slave side of booth_multiplier_if (a, b in; product, block out)
module booth_multiplier (
    input  logic              clk,
    input  logic              rst,
    booth_multiplier_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StStep,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  step_q, step_d;
    logic [15:0] a_q, a_d;
    logic [7:0]  b_q, b_d;
    logic [15:0] acc_q, acc_d;
    logic [15:0] product_q, product_d;

    logic [8:0]  b_ext;
    logic [2:0]  triplet;
    logic [15:0] pp;
    logic [15:0] pp_shift;
    logic [15:0] sum;

    // Appending a zero supplies the implicit b[-1] of the first triplet.
    assign b_ext = {b_q, 1'b0};

    always_comb begin
        triplet = 3'b000;
        if (state_q == StStep) begin
            triplet = b_ext[{step_q, 1'b0} +: 3];
        end
    end

    always_comb begin
        pp = 16'd0;
        unique case (triplet)
            3'b001, 3'b010: pp = a_q;
            3'b011:         pp = a_q << 1;
            3'b100:         pp = -(a_q << 1);
            3'b101, 3'b110: pp = -a_q;
            default:        pp = 16'd0;
        endcase
    end

    // Step i carries weight 4^i; all arithmetic wraps modulo 2^16.
    assign pp_shift = pp << {step_q, 1'b0};
    assign sum      = acc_q + pp_shift;

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        product_d = product_q;
        unique case (state_q)
            StIdle: begin
                state_d = StLoad;
            end
            StLoad: begin
                a_d     = {{8{bus.a[7]}}, bus.a};
                b_d     = bus.b;
                acc_d   = 16'd0;
                step_d  = 2'd0;
                state_d = StStep;
            end
            StStep: begin
                acc_d  = sum;
                step_d = step_q + 2'd1;
                if (step_q == 2'd3) begin
                    // Only the final sum is published; intermediates stay internal.
                    product_d = sum;
                    state_d   = StDone;
                end
            end
            StDone: begin
                state_d = StDone;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            step_q    <= 2'd0;
            a_q       <= 16'd0;
            b_q       <= 8'd0;
            acc_q     <= 16'd0;
            product_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            product_q <= product_d;
        end
    end

    assign bus.product = product_q;
    assign bus.block   = triplet;

endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier: a cycle-level behavioural model
// (edge count since reset release, operands captured at edge 2, plain signed
// multiplication) is compared against product/block on every falling edge,
// plus directed vectors with hand-computed literal results.
module tb_booth_multiplier;

    logic clk;
    logic rst;

    booth_multiplier_if bus ();

    booth_multiplier dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         cyc;   // rising edges since reset release (saturating)
    logic [7:0] ma;
    logic [7:0] mb;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc <= 0;
            ma  <= 8'd0;
            mb  <= 8'd0;
        end else begin
            if (cyc == 1) begin
                ma <= bus.a;
                mb <= bus.b;
            end
            if (cyc < 1000) cyc <= cyc + 1;
        end
    end

    function automatic logic [15:0] model_product(input int edges, input logic [7:0] x,
                                                  input logic [7:0] y);
        int sx;
        int sy;
        int p;
        sx = $signed(x);
        sy = $signed(y);
        p  = sx * sy;
        return (edges >= 6) ? p[15:0] : 16'd0;
    endfunction

    function automatic logic [2:0] model_block(input int edges, input logic [7:0] y);
        int bits;
        int t;
        if (edges < 2 || edges > 5) return 3'b000;
        bits = {23'd0, y, 1'b0};          // b[-1] = 0 at bit 0
        t    = (bits >> (2 * (edges - 2))) & 7;
        return t[2:0];
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_product", bus.product, 16'd0);
            chk("rst_block", {13'd0, bus.block}, 16'd0);
        end else begin
            chk("model_product", bus.product, model_product(cyc, ma, mb));
            chk("model_block", {13'd0, bus.block}, {13'd0, model_block(cyc, mb)});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic start_mul(input logic [7:0] va, input logic [7:0] vb);
        rst   = 1'b1;
        bus.a = va;
        bus.b = vb;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    typedef struct {
        logic [7:0]  va;
        logic [7:0]  vb;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{8'd5,   8'd5,   16'd25};
        vecs[1] = '{8'd2,   8'd6,   16'd12};
        vecs[2] = '{8'd7,   8'd5,   16'd35};
        vecs[3] = '{8'hFD,  8'd7,   16'hFFEB};
        vecs[4] = '{8'd127, 8'h80,  16'hC080};
        vecs[5] = '{8'h80,  8'h80,  16'h4000};
        vecs[6] = '{8'd37,  8'hFF,  16'hFFDB};
        vecs[7] = '{8'h80,  8'hFF,  16'h0080};
        vecs[8] = '{8'd0,   8'd99,  16'd0};
        vecs[9] = '{8'd55,  8'd0,   16'd0};

        rst   = 1'b1;
        bus.a = 8'd0;
        bus.b = 8'd0;
        edges(2);
        chk("reset_product", bus.product, 16'd0);
        chk("reset_block", {13'd0, bus.block}, 16'd0);

        // 2 x 5: block sequence and latency
        start_mul(8'd2, 8'd5);
        edges(1);
        chk("blk_load", {13'd0, bus.block}, 16'd0);
        edges(1);
        chk("blk_step0", {13'd0, bus.block}, 16'b010);
        edges(1);
        chk("blk_step1", {13'd0, bus.block}, 16'b010);
        edges(1);
        chk("blk_step2", {13'd0, bus.block}, 16'b000);
        edges(1);
        chk("prod_before_edge6", bus.product, 16'd0);
        edges(1);
        chk("prod_2x5", bus.product, 16'd10);
        chk("blk_done", {13'd0, bus.block}, 16'd0);
        edges(10);
        chk("prod_2x5_held", bus.product, 16'd10);

        foreach (vecs[i]) begin
            start_mul(vecs[i].va, vecs[i].vb);
            edges(6);
            chk($sformatf("vec%0d", i), bus.product, vecs[i].exp);
        end

        // Abort 7 x 5 mid-step: outputs clear without a clock edge
        start_mul(8'd7, 8'd5);
        edges(3);
        chk("abort_blk_pre", {13'd0, bus.block}, 16'b010);
        rst = 1'b1;
        #1;
        chk("abort_product", bus.product, 16'd0);
        chk("abort_block", {13'd0, bus.block}, 16'd0);
        start_mul(8'd3, 8'd4);
        edges(6);
        chk("after_abort_3x4", bus.product, 16'd12);

        // Abort from DONE clears product asynchronously
        rst = 1'b1;
        #1;
        chk("abort_done_product", bus.product, 16'd0);

        // Operand changes after LOAD and in DONE are ignored
        start_mul(8'd7, 8'd5);
        edges(2);
        bus.a = 8'd1;
        bus.b = 8'd1;
        edges(4);
        chk("ignore_after_load", bus.product, 16'd35);
        bus.a = 8'hFF;
        bus.b = 8'hFF;
        edges(5);
        chk("ignore_in_done", bus.product, 16'd35);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/booth_multiplier.md
# booth_multiplier

Sequential 8×8 signed multiplier using radix-4 (modified Booth) recoding of the multiplier operand, producing a 16-bit two's-complement product. It is a stand-alone arithmetic block. A multiplication is started by pulsing reset with the operands applied; the result is read from `product` a fixed number of cycles later. The current Booth recoding triplet is exported on `block` for debug and visibility.

## Interface
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-high reset; clears all state and arms a new multiplication.
- `a`  input  8  multiplicand, two's complement.
- `b`  input  8  multiplier, two's complement; Booth-recoded.
- `product`  output  16  signed product a×b; holds the final value until the next reset.
- `block`  output  3  recoding triplet {b[2i+1], b[2i], b[2i−1]} of the step currently executing; b[−1]=0.

## Operation
- FSM states: IDLE → LOAD → STEP (i = 0..3) → DONE.
- Reset (async, rst=1):
  - state=IDLE, step counter=0.
  - Internal accumulator, operand registers, `product` and `block` all cleared to 0.
- IDLE: on the first rising edge with rst=0, go to LOAD.
- LOAD edge:
  - Capture `a` into a 16-bit register, sign-extended.
  - Capture `b` into an 8-bit register.
  - accumulator=0, i=0; go to STEP.
- STEP i, on each edge:
  - Triplet t = {B[2i+1], B[2i], B[2i−1]}.
  - Partial product by t: 000/111 → 0; 001/010 → +A; 011 → +2A; 100 → −2A; 101/110 → −A.
  - Partial product is shifted left by 2i and added to the 16-bit accumulator, modulo 2^16.
  - i increments.
  - After step 3, write accumulator+pp into `product` and go to DONE.
- DONE: `product` held, `block`=000; `a` and `b` are ignored. Stays in DONE until reset.
- `block` is combinational from the state and step index: it shows t during STEP and 000 in every other state.
- `product` is registered. It reads 0 from reset until the final step edge, and never shows intermediate sums.
- Changes to `a`/`b` after the LOAD edge have no effect on the result in progress.
- The 16-bit result is exact for every signed 8-bit pair, e.g. (−128)×(−128)=+16384.

## Timing
- Edges are counted after rst falls.
- Edge 1 (IDLE→LOAD): no operand capture yet.
- Edge 2: operands captured.
- Edges 3–6: steps 0–3.
- `product` valid after edge 6, i.e. latency of 6 rising edges from reset release.
- `block` shows step i's triplet during the cycle that precedes that step's edge.
- Reset asserted mid-operation: the computation is aborted immediately (async); `product`=0, `block`=000. A new multiplication starts on release.
- Operands must be stable at edge 2. Changing them in the same delta as the rst release is legal because capture is one edge later.
- No overflow or saturation logic is required.

## Test plan
- a=2, b=5, reset release:
  - `product`=0 until edge 6, then 10, held for ≥10 further cycles.
  - `block` sequence during steps: 010, 010, 000, 000.
- Pulse reset, a=5, b=5 → `product`=25. Then a=2, b=6 → 12. Then a=7, b=5 → 35.
- Signed cases:
  - a=−3 (8'hFD), b=7 → 16'hFFEB (−21).
  - a=127, b=−128 → 16'hC080 (−16256).
  - a=−128, b=−128 → 16'h4000.
  - Cases with b=−1 (all triplets 111/110) → −a.
- Assert rst during step 2 of 7×5:
  - `product` and `block` go to 0 asynchronously, without waiting for a clock.
  - After release with a=3, b=4 → 12 after edge 6.
- Change a/b in DONE and after the LOAD edge → `product` unchanged until the next reset.
- Zero operands: a=0 or b=0 → `product`=0; b=0 gives `block`=000 in all steps.
